// File: rtl/blowfish128_stream_ctrl_if.sv
// Purpose : 128-bit valid/ready block stream between the host/DMA side and the
//           blowfish128 stream sequencer. One instance carries one direction.
// Signals : valid - producer has a block on data
//           ready - consumer takes the block on an edge where valid is high
//           data  - 128-bit block
// Modports: master - block producer (drives valid/data, samples ready)
//           slave  - block consumer (samples valid/data, drives ready)
interface blowfish128_stream_ctrl_if;
   logic         valid;
   logic         ready;
   logic [127:0] data;

   modport master (output valid, output data, input ready);
   modport slave (input valid, input data, output ready);
endinterface

// File: rtl/blowfish128_stream_ctrl.sv
// Purpose : Initiator-side sequencer for the blowfish128 core. Takes one 128-bit
//           block at a time from in_s, drives the core with Enable held high
//           until cipherReady (or a timeout), returns the result on out_s and
//           then keeps Enable low for GAP_CYCLES so the core restarts cleanly.
//           ECB and CBC chaining are supported in both directions.
// Ports   : Clk, Rst              - clock, synchronous active-high reset
//           cfg_*                 - configuration, latched by cfg_load in IDLE
//           in_s  (slave)         - input block stream
//           out_s (master)        - result stream
//           busy                  - sequencer not idle
//           timeout_err           - sticky, set when the core never readied
//           core_*                - drive/sample the blowfish128 core
module blowfish128_stream_ctrl #(
   parameter int unsigned GAP_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = 11
) (
   input  logic                             Clk,
   input  logic                             Rst,
   input  logic                             cfg_load,
   input  logic [63:0]                      cfg_key0,
   input  logic [63:0]                      cfg_key1,
   input  logic [63:0]                      cfg_key2,
   input  logic [63:0]                      cfg_key3,
   input  logic [63:0]                      cfg_key4,
   input  logic [63:0]                      cfg_key5,
   input  logic [63:0]                      cfg_key6,
   input  logic [63:0]                      cfg_key7,
   input  logic [3:0]                       cfg_key_length,
   input  logic                             cfg_encrypt,
   input  logic                             cfg_cbc,
   input  logic [127:0]                     cfg_iv,
   blowfish128_stream_ctrl_if.slave         in_s,
   blowfish128_stream_ctrl_if.master        out_s,
   output logic                             busy,
   output logic                             timeout_err,
   output logic                             core_Enable,
   output logic                             core_Encrypt,
   output logic [127:0]                     core_plainText,
   output logic [63:0]                      core_key0,
   output logic [63:0]                      core_key1,
   output logic [63:0]                      core_key2,
   output logic [63:0]                      core_key3,
   output logic [63:0]                      core_key4,
   output logic [63:0]                      core_key5,
   output logic [63:0]                      core_key6,
   output logic [63:0]                      core_key7,
   output logic [3:0]                       core_key_length,
   input  logic [127:0]                     core_cipherText,
   input  logic                             core_cipherReady
);

   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GapLast     = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StRun, StOut, StGap} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [7:0][63:0]    key_q, key_d;
   logic [3:0]          klen_q, klen_d;
   logic                enc_q, enc_d;
   logic                cbc_q, cbc_d;
   logic [127:0]        chain_q, chain_d;
   logic [127:0]        saved_q, saved_d;
   logic [127:0]        pt_q, pt_d;
   logic                en_q, en_d;
   logic                ov_q, ov_d;
   logic [127:0]        od_q, od_d;
   logic                terr_q, terr_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      key_d      = key_q;
      klen_d     = klen_q;
      enc_d      = enc_q;
      cbc_d      = cbc_q;
      chain_d    = chain_q;
      saved_d    = saved_q;
      pt_d       = pt_q;
      en_d       = en_q;
      ov_d       = ov_q;
      od_d       = od_q;
      terr_d     = terr_q;
      in_s.ready = (state_q == StIdle) && !cfg_load;

      unique case (state_q)
         StIdle: begin
            // cfg_load has priority over an offered block
            if (cfg_load) begin
               key_d   = {cfg_key7, cfg_key6, cfg_key5, cfg_key4,
                          cfg_key3, cfg_key2, cfg_key1, cfg_key0};
               klen_d  = cfg_key_length;
               enc_d   = cfg_encrypt;
               cbc_d   = cfg_cbc;
               chain_d = cfg_iv;
               terr_d  = 1'b0;
            end else if (in_s.valid) begin
               pt_d    = (cbc_q && enc_q) ? (in_s.data ^ chain_q) : in_s.data;
               saved_d = in_s.data;
               cnt_d   = '0;
               en_d    = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            cnt_d = cnt_q + 1'b1;
            if (core_cipherReady) begin
               od_d = (cbc_q && !enc_q) ? (core_cipherText ^ chain_q) : core_cipherText;
               // Encrypt chains on ciphertext out, decrypt on ciphertext in
               if (cbc_q) begin
                  chain_d = enc_q ? core_cipherText : saved_q;
               end
               ov_d    = 1'b1;
               en_d    = 1'b0;
               state_d = StOut;
            end else if (cnt_q == TimeoutLast) begin
               en_d    = 1'b0;
               terr_d  = 1'b1;
               cnt_d   = '0;
               state_d = StGap;
            end
         end
         StOut: begin
            if (out_s.ready) begin
               ov_d    = 1'b0;
               cnt_d   = '0;
               state_d = StGap;
            end
         end
         StGap: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == GapLast) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         key_q   <= '0;
         klen_q  <= '0;
         enc_q   <= 1'b0;
         cbc_q   <= 1'b0;
         chain_q <= '0;
         saved_q <= '0;
         pt_q    <= '0;
         en_q    <= 1'b0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         klen_q  <= klen_d;
         enc_q   <= enc_d;
         cbc_q   <= cbc_d;
         chain_q <= chain_d;
         saved_q <= saved_d;
         pt_q    <= pt_d;
         en_q    <= en_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         terr_q  <= terr_d;
      end
   end

   assign busy            = (state_q != StIdle);
   assign timeout_err     = terr_q;
   assign core_Enable     = en_q;
   assign core_Encrypt    = enc_q;
   assign core_plainText  = pt_q;
   assign core_key0       = key_q[0];
   assign core_key1       = key_q[1];
   assign core_key2       = key_q[2];
   assign core_key3       = key_q[3];
   assign core_key4       = key_q[4];
   assign core_key5       = key_q[5];
   assign core_key6       = key_q[6];
   assign core_key7       = key_q[7];
   assign core_key_length = klen_q;
   assign out_s.valid     = ov_q;
   assign out_s.data      = od_q;

endmodule

// File: tb/tb_blowfish128_stream_ctrl.sv
// Purpose : Self-checking bench for blowfish128_stream_ctrl. A core stub answers
//           20 cycles after Enable rises with cipherText = plainText ^ {2{key0}};
//           a reference model of ECB/CBC chaining predicts every result.
module tb_blowfish128_stream_ctrl;
   localparam int unsigned Gap = 2;
   localparam int unsigned Tmo = 64;
   localparam logic [63:0]  K0 = 64'haabb_0918_2736_ccdd;
   localparam logic [127:0] P1 = {2{64'h1234_56ab_cd13_2536}};
   localparam logic [127:0] C1 = {2{64'hb88f_5fb3_ea25_e9eb}};
   localparam logic [127:0] Cb0 = 128'haabb09182736ccdd_aabb09182736ccdc;

   logic Clk = 1'b0;
   logic Rst;
   always #5 Clk = ~Clk;

   logic          cfg_load, cfg_encrypt, cfg_cbc;
   logic [63:0]   cfg_key0, cfg_key1, cfg_key2, cfg_key3;
   logic [63:0]   cfg_key4, cfg_key5, cfg_key6, cfg_key7;
   logic [3:0]    cfg_key_length;
   logic [127:0]  cfg_iv;
   logic          busy, timeout_err, core_Enable, core_Encrypt, core_cipherReady;
   logic [127:0]  core_plainText, core_cipherText;
   logic [63:0]   core_key0, core_key1, core_key2, core_key3;
   logic [63:0]   core_key4, core_key5, core_key6, core_key7;
   logic [3:0]    core_key_length;

   blowfish128_stream_ctrl_if in_if ();
   blowfish128_stream_ctrl_if out_if ();

   blowfish128_stream_ctrl #(
      .GAP_CYCLES     (Gap),
      .TIMEOUT_CYCLES (Tmo),
      .CNT_W          (11)
   ) dut (
      .Clk              (Clk),
      .Rst              (Rst),
      .cfg_load         (cfg_load),
      .cfg_key0         (cfg_key0),
      .cfg_key1         (cfg_key1),
      .cfg_key2         (cfg_key2),
      .cfg_key3         (cfg_key3),
      .cfg_key4         (cfg_key4),
      .cfg_key5         (cfg_key5),
      .cfg_key6         (cfg_key6),
      .cfg_key7         (cfg_key7),
      .cfg_key_length   (cfg_key_length),
      .cfg_encrypt      (cfg_encrypt),
      .cfg_cbc          (cfg_cbc),
      .cfg_iv           (cfg_iv),
      .in_s             (in_if),
      .out_s            (out_if),
      .busy             (busy),
      .timeout_err      (timeout_err),
      .core_Enable      (core_Enable),
      .core_Encrypt     (core_Encrypt),
      .core_plainText   (core_plainText),
      .core_key0        (core_key0),
      .core_key1        (core_key1),
      .core_key2        (core_key2),
      .core_key3        (core_key3),
      .core_key4        (core_key4),
      .core_key5        (core_key5),
      .core_key6        (core_key6),
      .core_key7        (core_key7),
      .core_key_length  (core_key_length),
      .core_cipherText  (core_cipherText),
      .core_cipherReady (core_cipherReady)
   );

   // Core stub: counts consecutive Enable-high edges
   int unsigned en_cnt;
   logic        stub_on;
   always @(posedge Clk) begin
      if (!core_Enable) en_cnt <= 0;
      else              en_cnt <= en_cnt + 1;
   end
   assign core_cipherReady = stub_on && core_Enable && (en_cnt == 20);
   assign core_cipherText  = core_plainText ^ {2{core_key0}};

   int ncmp;
   int nfail;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Reference model state
   logic         m_enc, m_cbc;
   logic [127:0] m_chain;
   logic [63:0]  m_k0;

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic load_cfg(input logic [63:0] k0, input logic enc, input logic cbc,
                           input logic [127:0] iv);
      logic [63:0] k7;
      k7 = {$urandom, $urandom};
      cfg_key0 = k0;            cfg_key1 = {$urandom, $urandom};
      cfg_key2 = {$urandom, $urandom}; cfg_key3 = {$urandom, $urandom};
      cfg_key4 = {$urandom, $urandom}; cfg_key5 = {$urandom, $urandom};
      cfg_key6 = {$urandom, $urandom}; cfg_key7 = k7;
      cfg_key_length = 4'd2;
      cfg_encrypt = enc;
      cfg_cbc = cbc;
      cfg_iv = iv;
      cfg_load = 1'b1;
      in_if.valid = 1'b1;
      in_if.data = rnd128();
      #1;
      check1("cfg_wins_in_ready", in_if.ready, 1'b0);
      @(negedge Clk);
      cfg_load = 1'b0;
      in_if.valid = 1'b0;
      check1("cfg_no_accept_busy", busy, 1'b0);
      check1("cfg_clears_terr", timeout_err, 1'b0);
      check("cfg_key0", 128'(core_key0), 128'(k0));
      check("cfg_key7", 128'(core_key7), 128'(k7));
      check("cfg_klen", 128'(core_key_length), 128'(4'd2));
      check1("cfg_encrypt", core_Encrypt, enc);
      m_enc = enc;
      m_cbc = cbc;
      m_chain = iv;
      m_k0 = k0;
   endtask

   // Offer one block, wait for the stub, drain with bp cycles of backpressure
   task automatic send(input logic [127:0] d, input int bp);
      logic [127:0] exp_pt, exp_out, ct;
      int n;
      if (m_enc) begin
         exp_pt = m_cbc ? (d ^ m_chain) : d;
         ct = exp_pt ^ {2{m_k0}};
         exp_out = ct;
         if (m_cbc) m_chain = ct;
      end else begin
         exp_pt = d;
         ct = d ^ {2{m_k0}};
         exp_out = m_cbc ? (ct ^ m_chain) : ct;
         if (m_cbc) m_chain = d;
      end
      n = 0;
      while (!in_if.ready && n < 50) begin
         @(negedge Clk);
         n++;
      end
      check1("in_ready_idle", in_if.ready, 1'b1);
      in_if.valid = 1'b1;
      in_if.data = d;
      @(negedge Clk);
      in_if.valid = 1'b0;
      in_if.data = rnd128();
      check1("enable_on_accept", core_Enable, 1'b1);
      check("plaintext", core_plainText, exp_pt);
      n = 0;
      while (!core_cipherReady && n < 100) begin
         @(negedge Clk);
         n++;
      end
      check("run_len", 128'(n), 128'(20));
      check1("out_valid_early", out_if.valid, 1'b0);
      check("plaintext_held", core_plainText, exp_pt);
      @(negedge Clk);
      check1("out_valid_rise", out_if.valid, 1'b1);
      check("out_data", out_if.data, exp_out);
      check1("enable_drop", core_Enable, 1'b0);
      for (int i = 0; i < bp; i++) begin
         @(negedge Clk);
         check1("bp_valid", out_if.valid, 1'b1);
         check("bp_data", out_if.data, exp_out);
         check1("bp_in_ready", in_if.ready, 1'b0);
         check1("bp_enable", core_Enable, 1'b0);
      end
      out_if.ready = 1'b1;
      @(negedge Clk);
      out_if.ready = 1'b0;
      check1("valid_drop", out_if.valid, 1'b0);
      check1("gap1_busy", busy, 1'b1);
      check1("gap1_enable", core_Enable, 1'b0);
      @(negedge Clk);
      check1("gap2_busy", busy, 1'b1);
      @(negedge Clk);
      check1("idle_after_gap", busy, 1'b0);
      check1("in_ready_after_gap", in_if.ready, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      logic seen_ov;
      ncmp = 0;
      nfail = 0;
      Rst = 1'b1;
      stub_on = 1'b1;
      cfg_load = 1'b0; cfg_encrypt = 1'b0; cfg_cbc = 1'b0; cfg_iv = '0;
      cfg_key0 = '0; cfg_key1 = '0; cfg_key2 = '0; cfg_key3 = '0;
      cfg_key4 = '0; cfg_key5 = '0; cfg_key6 = '0; cfg_key7 = '0;
      cfg_key_length = '0;
      in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b0;
      repeat (2) @(negedge Clk);
      check1("rst_busy", busy, 1'b0);
      check1("rst_out_valid", out_if.valid, 1'b0);
      check1("rst_enable", core_Enable, 1'b0);
      check("rst_out_data", out_if.data, '0);
      check("rst_plaintext", core_plainText, '0);
      check1("rst_terr", timeout_err, 1'b0);
      check("rst_key0", 128'(core_key0), '0);
      Rst = 1'b0;
      @(negedge Clk);
      check1("rst_in_ready", in_if.ready, 1'b1);

      // 1: ECB encrypt
      load_cfg(K0, 1'b1, 1'b0, '0);
      send(P1, 0);
      check("t1_ecb_const", out_if.data, C1);

      // 2: CBC encrypt, IV = 1
      load_cfg(K0, 1'b1, 1'b1, 128'h1);
      send('0, 0);
      check("t2_c0_const", out_if.data, Cb0);
      send('0, 0);
      check("t2_c1_const", out_if.data, 128'h1);

      // 3: CBC decrypt of C0, C1
      load_cfg(K0, 1'b0, 1'b1, 128'h1);
      send(Cb0, 0);
      check("t3_p0_const", out_if.data, '0);
      send(128'h1, 0);
      check("t3_p1_const", out_if.data, '0);
      check("t3_chain", dut.chain_q, 128'h1);

      // 4: backpressure
      load_cfg(K0, 1'b1, 1'b0, '0);
      send(P1, 10);
      check("t4_const", out_if.data, C1);

      // 5: timeout
      stub_on = 1'b0;
      load_cfg(K0, 1'b1, 1'b0, '0);
      in_if.valid = 1'b1;
      in_if.data = P1;
      @(negedge Clk);
      in_if.valid = 1'b0;
      n = 0;
      seen_ov = 1'b0;
      while (core_Enable && n < 200) begin
         if (out_if.valid) seen_ov = 1'b1;
         @(negedge Clk);
         n++;
      end
      check("tmo_high_cycles", 128'(n), 128'(Tmo));
      check1("tmo_terr", timeout_err, 1'b1);
      check1("tmo_no_out_valid", seen_ov | out_if.valid, 1'b0);
      check1("tmo_gap_busy", busy, 1'b1);
      check1("tmo_gap_in_ready", in_if.ready, 1'b0);
      repeat (Gap) @(negedge Clk);
      check1("tmo_idle", busy, 1'b0);
      check1("tmo_in_ready", in_if.ready, 1'b1);
      check1("tmo_terr_sticky", timeout_err, 1'b1);
      stub_on = 1'b1;
      load_cfg(K0, 1'b1, 1'b0, '0);

      // 6: reset on the 5th RUN cycle
      load_cfg(K0, 1'b1, 1'b1, rnd128());
      in_if.valid = 1'b1;
      in_if.data = P1;
      @(negedge Clk);
      in_if.valid = 1'b0;
      repeat (4) @(negedge Clk);
      check1("t6_running", core_Enable, 1'b1);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      check1("t6_enable", core_Enable, 1'b0);
      check1("t6_busy", busy, 1'b0);
      check1("t6_out_valid", out_if.valid, 1'b0);
      check("t6_chain", dut.chain_q, '0);
      check("t6_key0", 128'(core_key0), '0);
      load_cfg(K0, 1'b1, 1'b0, '0);
      send(P1, 0);
      check("t6_ecb_const", out_if.data, C1);

      // Randomized modes, keys and data against the model
      for (int it = 0; it < 8; it++) begin
         load_cfg({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  rnd128());
         for (int b = 0; b < 3; b++) begin
            send(rnd128(), int'($urandom_range(0, 4)));
         end
         if (m_cbc) check("rnd_chain", dut.chain_q, m_chain);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule

// File: doc/blowfish128_stream_ctrl.md
Name: blowfish128_stream_ctrl

Overview:
- Initiator-side sequencer for the blowfish128 core: it drives the core's Enable/Encrypt/plainText/key inputs and consumes cipherText/cipherReady.
- Accepts 128-bit blocks on a valid/ready input stream and returns results on a valid/ready output stream.
- Enforces the core's restart protocol: Enable is dropped between blocks.
- Supports ECB and CBC chaining in both directions. Sits between the host/DMA stream and blowfish128_top.

Parameters:
GAP_CYCLES, 2, cycles core_Enable is held low between blocks (min 1)
TIMEOUT_CYCLES, 1024, max core_Enable-high cycles waiting for core_cipherReady
CNT_W, 11, width of the wait/gap counter (must hold TIMEOUT_CYCLES)

Ports:
Clk  in  1  clock, all logic on rising edge
Rst  in  1  synchronous, active-high reset
cfg_load  in  1  latch configuration (honoured only in IDLE)
cfg_key0..cfg_key7  in  64 each  key words
cfg_key_length  in  4  key length code, passed through to core
cfg_encrypt  in  1  1 = encrypt, 0 = decrypt
cfg_cbc  in  1  1 = CBC, 0 = ECB
cfg_iv  in  128  CBC initial vector
in_valid / in_ready / in_data  in / out / in  1 / 1 / 128  input block stream
out_valid / out_ready / out_data  out / in / out  1 / 1 / 128  result stream
busy  out  1  state != IDLE
timeout_err  out  1  sticky timeout flag
core_Enable, core_Encrypt  out  1 each  to core
core_plainText  out  128  to core
core_key0..core_key7  out  64 each  to core (registered config)
core_key_length  out  4  to core
core_cipherText  in  128  from core
core_cipherReady  in  1  from core

Behaviour:
- Reset: all outputs, config registers and the chain register go to 0. State goes to IDLE.
- States: IDLE, RUN, OUT, GAP.
- in_ready = (state==IDLE) && !cfg_load. When cfg_load and in_valid are both high, cfg_load wins and no block is accepted.
- cfg_load in IDLE latches all cfg_* inputs, loads chain <= cfg_iv and clears timeout_err. cfg_load is ignored in every other state.
- IDLE, on accept (in_valid && in_ready) at edge N:
  - core_plainText <= (cbc && enc) ? in_data^chain : in_data.
  - saved <= in_data; counter <= 0; go to RUN.
  - core_Enable = 1 from edge N onward.
- RUN:
  - core_Enable stays high; core_plainText, keys and Encrypt are held stable; counter increments.
  - If core_cipherReady is sampled high:
    - out_data <= (cbc && !enc) ? core_cipherText^chain : core_cipherText.
    - chain <= enc ? core_cipherText : saved (chain is unchanged in ECB).
    - out_valid <= 1; core_Enable <= 0; go to OUT.
  - Otherwise, if counter == TIMEOUT_CYCLES-1: core_Enable <= 0, timeout_err <= 1, block discarded, chain unchanged, go to GAP.
- OUT: out_valid and out_data are held stable until out_ready is high. On that edge out_valid <= 0; go to GAP.
- GAP: core_Enable low for GAP_CYCLES cycles, then go to IDLE.
- core_cipherReady is ignored outside RUN.
- Latency: out_valid rises on the edge after the first cycle with core_cipherReady high.
- Throughput: one block in flight at a time; there is no input buffering beyond the single saved block.
- Rst mid-operation: next edge gives IDLE, core_Enable 0, out_valid 0, the in-flight block is discarded and chain = 0. Config must be reloaded.

Test Plan:
Bench uses a core stub: after 20 consecutive cycles with core_Enable high it asserts cipherReady for one cycle, with cipherText = plainText ^ {2{key0}}. key0 = aabb_0918_2736_ccdd, key_length = 2.
1. ECB encrypt, P = 1234_56ab_cd13_2536 repeated twice -> out_data = b88f_5fb3_ea25_e9eb repeated twice. out_valid rises one edge after cipherReady; core_Enable is low within GAP_CYCLES.
2. CBC encrypt, IV = 128'h1, blocks P0 = P1 = 0:
   - C0 = aabb09182736ccdd_aabb09182736ccdc.
   - C1 = 128'h1.
3. CBC decrypt of C0, C1 with the same IV -> outputs 0, then 0. The chain register ends at C1.
4. Backpressure: out_ready low for 10 cycles -> out_valid stays 1, out_data stable, in_ready 0, core_Enable 0. Release -> out_valid drops, then GAP, then IDLE.
5. Timeout: stub never readies, TIMEOUT_CYCLES = 64 -> core_Enable drops after 64 high cycles, timeout_err = 1, out_valid never asserts, in_ready returns after GAP. cfg_load clears timeout_err.
6. Rst asserted on the 5th RUN cycle -> next edge core_Enable 0, busy 0, out_valid 0. After reload, scenario 1 passes unchanged.
